// File: rtl/cic_dec.sv
// Order-3 CIC decimator: three integrators at the input rate, decimate by 2^RLOG2,
// three unit-delay combs at the output rate. Full precision, modulo 2^(Win+Wg).
module cic_dec #(
  parameter int unsigned Win   = 16,
  parameter int unsigned RLOG2 = 3,
  parameter int unsigned Wg    = 3 * RLOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Win-1:0]      i_data,
  input  logic                val_in,
  output logic [Win+Wg-1:0]   o_data,
  output logic                val_out
);

  localparam int unsigned W  = Win + Wg;
  localparam int unsigned NS = 3;
  localparam logic [RLOG2-1:0] CNT_LAST = RLOG2'((1 << RLOG2) - 1);

  logic [Win-1:0]   smp_q;
  logic             smp_v;
  logic [W-1:0]     smp_ext;

  logic [W-1:0]     acc [NS];
  logic [NS-1:0]    iv;

  logic [RLOG2-1:0] cnt;
  logic [W-1:0]     dreg;
  logic             vd;

  logic [W-1:0]     cin  [NS];
  logic [NS-1:0]    cvin;
  logic [W-1:0]     cout [NS];
  logic [W-1:0]     dly  [NS];
  logic [NS-1:0]    cv;

  // Input capture stage; sign extension to full internal width happens here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q <= '0;
      smp_v <= 1'b0;
    end else begin
      smp_v <= val_in;
      if (val_in) smp_q <= i_data;
    end
  end

  assign smp_ext = {{Wg{smp_q[Win-1]}}, smp_q};

  // Integrator chain; wrap-around is intentional and cancelled by the combs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NS; k++) acc[k] <= '0;
      iv <= '0;
    end else begin
      iv[0] <= smp_v;
      if (smp_v) acc[0] <= acc[0] + smp_ext;
      for (int unsigned k = 1; k < NS; k++) begin
        iv[k] <= iv[k-1];
        if (iv[k-1]) acc[k] <= acc[k] + acc[k-1];
      end
    end
  end

  // Decimator: keep every R-th integrator output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dreg <= '0;
      vd   <= 1'b0;
    end else begin
      vd <= 1'b0;
      if (iv[NS-1]) begin
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          dreg <= acc[NS-1];
          vd   <= 1'b1;
        end else begin
          cnt <= cnt + RLOG2'(1);
        end
      end
    end
  end

  always_comb begin
    cin[0]  = dreg;
    cvin[0] = vd;
    for (int unsigned k = 1; k < NS; k++) begin
      cin[k]  = cout[k-1];
      cvin[k] = cv[k-1];
    end
  end

  // Comb chain at the low rate; outputs hold between valid strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NS; k++) begin
        cout[k] <= '0;
        dly[k]  <= '0;
      end
      cv <= '0;
    end else begin
      cv <= cvin;
      for (int unsigned k = 0; k < NS; k++) begin
        if (cvin[k]) begin
          cout[k] <= cin[k] - dly[k];
          dly[k]  <= cin[k];
        end
      end
    end
  end

  assign o_data  = cout[NS-1];
  assign val_out = cv[NS-1];

endmodule

// File: tb/tb_cic_dec.sv
// Randomized bench for cic_dec against a cumulative-sum / decimate / difference model
// mod 2^25, checking both value and arrival cycle of every output pulse.
module tb_cic_dec;

  localparam int unsigned WIN = 16;
  localparam int unsigned WO  = 25;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [WIN-1:0]  i_data = '0;
  logic            val_in = 1'b0;
  logic [WO-1:0]   o_data;
  logic            val_out;

  cic_dec dut (
    .clk    (clk),
    .rst    (rst),
    .i_data (i_data),
    .val_in (val_in),
    .o_data (o_data),
    .val_out(val_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WO-1:0] val;
    int            due;
  } exp_t;

  exp_t          expq [$];
  logic [WO-1:0] seen [$];
  logic [WO-1:0] c1, c2, c3, p1, p2, p3;
  logic [WO-1:0] last_out;
  int            nacc;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    c1 = '0; c2 = '0; c3 = '0;
    p1 = '0; p2 = '0; p3 = '0;
    nacc = 0;
    last_out = '0;
    expq.delete();
  endtask

  // Golden: triple running sum, every 8th value, triple first difference.
  task automatic model_push(input logic [WIN-1:0] s);
    logic [WO-1:0] x, d1, d2, d3;
    exp_t e;
    x  = WO'(signed'(s));
    c1 = c1 + x;
    c2 = c2 + c1;
    c3 = c3 + c2;
    nacc++;
    if (nacc % 8 == 0) begin
      d1 = c3 - p1; p1 = c3;
      d2 = d1 - p2; p2 = d1;
      d3 = d2 - p3; p3 = d2;
      e.val = d3;
      e.due = cyc + 8;
      expq.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input logic [WIN-1:0] d);
    @(negedge clk);
    #1;
    val_in = v;
    i_data = d;
    if (v) model_push(d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, WIN'($urandom));
  endtask

  task automatic sync_reset(input int n);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (n) begin
      val_in = 1'($urandom);
      i_data = WIN'($urandom);
      @(negedge clk);
      #1;
    end
    val_in = 1'b0;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic chk_step(input string tag, input int need);
    logic [WO-1:0] a, b, c;
    chk({tag, "_cnt"}, 32'(seen.size() >= need), 32'd1);
    a = (seen.size() > 0) ? seen[0] : '0;
    b = (seen.size() > 1) ? seen[1] : '0;
    c = (seen.size() > 2) ? seen[2] : '0;
    chk({tag, "_0"}, 32'(a), 32'd120);
    chk({tag, "_1"}, 32'(b), 32'd456);
    chk({tag, "_2"}, 32'(c), 32'd512);
  endtask

  // Output monitor: each pulse must match the oldest pending model value on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_vld", 32'(val_out), 32'd0);
      last_out = '0;
    end else if (val_out) begin
      chk("pending", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out", 32'(o_data), 32'(e.val));
        chk("due", 32'(cyc), 32'(e.due));
      end
      last_out = o_data;
      seen.push_back(o_data);
    end else begin
      chk("hold", 32'(o_data), 32'(last_out));
    end
  end

  initial begin
    int n;
    logic v;
    model_reset();

    sync_reset(5);

    // Step response, continuous valid
    seen.delete();
    repeat (40) drive(1'b1, 16'd1);
    idle(12);
    chk_step("step", 5);
    chk("step_3", 32'((seen.size() > 3) ? seen[3] : '0), 32'd512);
    chk("step_4", 32'((seen.size() > 4) ? seen[4] : '0), 32'd512);

    // Extremes, integrators wrap many times
    sync_reset(2);
    repeat (2000) drive(1'b1, 16'h8000);
    idle(12);
    chk("min_dc", 32'(last_out), 32'h0100_0000);
    chk("min_out", 32'(o_data), 32'h0100_0000);
    repeat (2000) drive(1'b1, 16'h7fff);
    idle(12);
    chk("max_dc", 32'(last_out), 32'd16776704);

    // Gapped valid
    sync_reset(2);
    seen.delete();
    n = 0;
    while (n < 48) begin
      v = 1'($urandom_range(0, 1));
      drive(v, 16'd1);
      if (v) n++;
    end
    idle(12);
    chk_step("gap", 6);
    chk("gap_pulses", 32'(seen.size()), 32'd6);

    // Asynchronous reset pulse mid-operation, between clock edges
    sync_reset(2);
    repeat (20) drive(1'b1, 16'd1);
    drive(1'b0, 16'd0);
    @(posedge clk);
    #2;
    chk("pre_arst", 32'(o_data != '0), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_data", 32'(o_data), 32'd0);
    chk("arst_vld", 32'(val_out), 32'd0);
    model_reset();
    #1;
    rst = 1'b1;
    seen.delete();
    repeat (30) drive(1'b1, 16'd1);
    idle(12);
    chk_step("rerun", 3);

    // Random reference check
    sync_reset(2);
    n = 0;
    while (n < 10000) begin
      v = ($urandom_range(0, 9) != 0);
      drive(v, WIN'($urandom));
      if (v) n++;
    end
    idle(12);
    chk("drain", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_dec.md
Name: cic_dec

Overview:
- Order-3 CIC decimation filter with full-precision, wrap-around arithmetic. It is the receive-side counterpart of the CIC interpolator.
- Data path: three integrators at the input (high) rate, a decimate-by-R stage, then three comb stages (differential delay M=1) at the output (low) rate.
- Output grows by 3*log2(R) bits.

Parameters:
- Win, 16, input sample width (signed two's complement).
- RLOG2, 3, log2 of the decimation factor R (R = 2^RLOG2 = 8).
- Wg, 3*RLOG2 = 9, guard bits. Must equal 3*RLOG2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- i_data  input  Win  signed input sample.
- val_in  input  1  input sample qualifier, one sample per high cycle.
- o_data  output  Win+Wg  signed decimated output.
- val_out  output  1  one-cycle pulse marking a new o_data.

Behaviour:
- Reset (rst low, asynchronous):
  - All accumulators, comb delay registers, stage valids, decimation counter and o_data clear to 0.
  - val_out = 0.
  - Reset mid-operation discards all history. The first output after release follows exactly the fresh-start sequence.
- Internal width: every stage register is Win+Wg bits. i_data is sign-extended on entry.
- Arithmetic is modulo 2^(Win+Wg), with no saturation. Integrator overflow is required and harmless: the final output is exact whenever the true result fits.
- Integrator stage k (k=1..3): on a clock edge where its input valid is 1, acc_k <= acc_k + in_k, and v_k <= 1; otherwise acc_k holds and v_k <= 0.
  - in_1 = i_data (sign-extended), valid = val_in.
  - in_k = acc_(k-1), valid = v_(k-1).
- Decimator:
  - Counter cnt runs 0..R-1 and advances only when v_3 = 1.
  - When v_3 = 1 and cnt = R-1: capture acc_3 into dreg, vd <= 1, cnt <= 0.
  - Otherwise vd <= 0.
  - The first output corresponds to the R-th valid input after reset.
- Comb stage k (k=1..3): when its input valid is 1, out_k <= in_k - dly_k, dly_k <= in_k, and vc_k <= 1; otherwise all hold and vc_k <= 0.
  - Comb 1 is fed by dreg/vd.
  - o_data = out_3 and val_out = vc_3, both registered.
- Latency: val_in high at edge t for the R-th sample gives val_out high during the cycle after edge t+7, i.e. 7 clocks of pipeline.
- o_data holds its value between pulses.
- Gaps in val_in: any pattern of low cycles only stalls the filter. The output sample values equal those of the same input sequence with val_in held continuously high; only timing differs.
- Gain: DC gain = R^3 = 512.
  - Input +32767 gives output 16776704.
  - Input -32768 gives output -16777216, which fits exactly in 25 bits.
- val_in must not be asserted while rst is low; inputs in that state are ignored.

Test Plan:
- Reset values: hold rst low 5 cycles with random i_data and val_in -> o_data = 0 and val_out = 0 throughout. Pulse rst low asynchronously mid-cycle -> outputs clear with no clock edge.
- Step response: i_data = 1 with val_in continuously high -> successive val_out pulses carry 120, 456, 512, 512, ... Pulses are spaced 8 cycles apart, and the first arrives 7 clocks after the 8th valid input.
- Extremes and wrap: i_data = -32768 held for 2000 samples -> steady output -16777216. Then i_data = +32767 held for 2000 samples -> output settles to 16776704. Integrators wrap many times with no error.
- Gapped valid: the step stimulus with val_in randomly low about 50% of cycles -> same value sequence 120, 456, 512, ... Exactly one val_out pulse per 8 accepted samples, and no pulse without new data.
- Reset mid-operation: run the step for 20 samples, assert rst, release, restart the step -> outputs 120, 456, 512 again, with no residue from the earlier run.
- Random reference check: 10000 random 16-bit samples compared against a golden model (triple cumulative sum, take every 8th value, triple first difference, all modulo 2^25) -> bit-exact match on every val_out pulse.
